// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: D = (A - B) mod 2^WIDTH, Bo = (A < B).
// One difference bit per clock, LSB first, with an IDLE/RUN/FIN handshake.
module subtrator_serial #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic [WIDTH-1:0] resShift;
    logic             borrowReg;
    logic [CNT_W-1:0] bitCount;

    logic aBit;
    logic bBit;
    logic diffBit;
    logic borrowNext;
    logic lastBit;

    // Full-subtractor cell applied to the current LSBs of the operand shifters.
    assign aBit       = aShift[0];
    assign bBit       = bShift[0];
    assign diffBit    = aBit ^ bBit ^ borrowReg;
    assign borrowNext = (~aBit & bBit) | (~(aBit ^ bBit) & borrowReg);
    assign lastBit    = (bitCount == LAST_COUNT);

    // NOTE: nextState gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (START) nextState = RUN;
            RUN:     if (lastBit) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Status flags come straight from the state register, so they are glitch-free
    // and mutually exclusive.
    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Datapath: operands are captured on accept, then shifted right once per RUN edge.
    // NOTE: these are plain registers, not a memory array, so all of them take the async reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            aShift    <= '0;
            bShift    <= '0;
            resShift  <= '0;
            borrowReg <= 1'b0;
            bitCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        aShift    <= A;
                        bShift    <= B;
                        resShift  <= '0;
                        borrowReg <= 1'b0;
                        bitCount  <= '0;
                    end
                end
                RUN: begin
                    aShift    <= aShift >> 1;
                    bShift    <= bShift >> 1;
                    resShift  <= {diffBit, resShift[WIDTH-1:1]};
                    borrowReg <= borrowNext;
                    bitCount  <= bitCount + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers update only on the RUN-to-FIN edge, merging in the final bit
    // so D is valid in the same cycle DONE is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D  <= '0;
            Bo <= 1'b0;
        end else if (state == RUN && lastBit) begin
            D  <= {diffBit, resShift[WIDTH-1:1]};
            Bo <= borrowNext;
        end
    end

endmodule
